sha256_msg_schedule: RTL

SHA-256 message-schedule expander sitting directly downstream of the preprocessor. It accepts one padded 512-bit block over a valid/ready handshake and streams the 64 schedule words W0..W63 to the compression stage, one word per accepted output cycle, with back-pressure. Expansion is sequential, using a 16-word sliding window; no 64-word storage.

---
 rtl/sha256_msg_schedule.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sha256_msg_schedule.sv
// sha256_msg_schedule
// Expands one padded 512-bit SHA-256 block into the 64-word message schedule
// W0..W63. The words go out one per handshake. Only a 16-word sliding window
// is stored. Each accepted output word shifts the window down by one, and the
// next schedule word is computed into the top slot.
//
// Ports:
//   clk           rising-edge system clock
//   rst           asynchronous active-high reset
//   processedMsg  padded block, [511:480] = W0 ... [31:0] = W15
//   msg_valid     upstream offers a block
//   msg_ready     block is taken on an edge with msg_valid & msg_ready
//   w_out         current schedule word W[t]
//   w_index       t of w_out (0..63)
//   w_valid       w_out / w_index / w_last are meaningful
//   w_last        marks W63
//   w_ready       consumer takes the word on an edge with w_valid & w_ready
//   busy          a block is being streamed
module sha256_msg_schedule (
   input  logic         clk,
   input  logic         rst,
   input  logic [511:0] processedMsg,
   input  logic         msg_valid,
   output logic         msg_ready,
   output logic [31:0]  w_out,
   output logic [5:0]   w_index,
   output logic         w_valid,
   output logic         w_last,
   input  logic         w_ready,
   output logic         busy
);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t      state;
   state_t      nextState;
   logic [31:0] window [16];
   logic [5:0]  wordCount;
   logic        acceptBlock;
   logic        advanceWord;
   logic [31:0] newWord;

   // Small sigma functions of the SHA-256 schedule, written as rotations by
   // concatenation so they map to pure wiring plus XOR.
   function automatic logic [31:0] smallSigma0(input logic [31:0] x);
      smallSigma0 = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
   endfunction

   function automatic logic [31:0] smallSigma1(input logic [31:0] x);
      smallSigma1 = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
   endfunction

   assign acceptBlock = (state == IDLE) && msg_valid;
   assign advanceWord = (state == RUN) && w_ready;

   // The window holds W[t]..W[t+15]. So W[t+16] is built from window slots
   // 14, 9, 1 and 0. The 32-bit sum drops the carries, which gives mod 2^32.
   assign newWord = smallSigma1(window[14]) + window[9] + smallSigma0(window[1]) + window[0];

   // State register. Reset drops any partial block and returns to IDLE.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state decode. IDLE waits for a block. RUN leaves after the
   // handshake that consumes W63.
   always_comb begin
      nextState = state;
      case (state)
         IDLE: begin
            if (acceptBlock) begin
               nextState = RUN;
            end
         end
         RUN: begin
            if (advanceWord && (wordCount == 6'd63)) begin
               nextState = IDLE;
            end
         end
         default: nextState = IDLE;
      endcase
   end

   // Sliding window. It loads all sixteen words on the accept edge and shifts
   // on every output handshake. The word computed on the final handshake is
   // never shown, but it is harmless and keeps the shift logic uniform.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            window[i] <= '0;
         end
      end else if (acceptBlock) begin
         for (int i = 0; i < 16; i++) begin
            window[i] <= processedMsg[511 - 32*i -: 32];
         end
      end else if (advanceWord) begin
         for (int i = 0; i < 15; i++) begin
            window[i] <= window[i + 1];
         end
         window[15] <= newWord;
      end
   end

   // Word index t. It wraps naturally from 63 back to 0 as the block ends.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wordCount <= '0;
      end else if (acceptBlock) begin
         wordCount <= '0;
      end else if (advanceWord) begin
         wordCount <= wordCount + 6'd1;
      end
   end

   // Every output comes from a register or from the state decode. None of
   // them depends combinationally on msg_valid or w_ready.
   assign msg_ready = (state == IDLE);
   assign w_valid   = (state == RUN);
   assign busy      = (state == RUN);
   assign w_out     = window[0];
   assign w_index   = wordCount;
   assign w_last    = (state == RUN) && (wordCount == 6'd63);

endmodule
